// File: rtl/i2c_target_regfile.sv
// I2C target with an 8-bit-addressed register file and a write side port.
// Bus pins are synchronized to clk_i; state changes follow SCL edges.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         NREGS    = 256
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o,
  input  logic [7:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;

  logic       r_scl_s1, r_scl_s2, r_scl_prev;
  logic       r_sda_s1, r_sda_s2, r_sda_prev;
  logic [3:0] r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_mack;
  logic       r_sda_oe;
  logic       r_wr_valid;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_rd_data;
  logic [7:0] r_dbg_data;
  logic [7:0] r_mem [NREGS];

  logic       w_start, w_stop, w_scl_rise, w_scl_fall;
  logic [7:0] w_byte;
  logic       w_ptr_ok, w_dbg_ok, w_wr_en;

  // Synchronizers idle high so reset release never fakes a bus event
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_s1   <= scl_i;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= sda_i;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
    end
  end

  assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
  assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_ptr_ok   = ({1'b0, r_ptr} < 9'(NREGS));
  assign w_dbg_ok   = ({1'b0, dbg_addr_i} < 9'(NREGS));
  assign w_wr_en    = !w_start && !w_stop && w_scl_rise &&
                      (r_state == S_WDATA) && (r_bitcnt == 4'd7);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= 4'd0;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 4'd0;
        r_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_bitcnt <= 4'd0;
        r_sda_oe <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (w_wr_en) begin
              r_wr_valid <= 1'b1;
              r_wr_addr  <= r_ptr;
              r_wr_data  <= w_byte;
            end
          end
          S_RDATA: r_bitcnt <= r_bitcnt + 4'd1;
          S_RDATA_ACK: begin
            r_mack <= r_sda_s2;
            if (!r_sda_s2) r_ptr <= r_ptr + 8'd1;
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: if (r_bitcnt == 4'd8) begin
            r_bitcnt <= 4'd0;
            if (r_shift[7:1] == DEV_ADDR) begin
              r_state  <= S_ADDR_ACK;
              r_sda_oe <= 1'b1;
              r_rw     <= r_shift[0];
            end else begin
              r_state <= S_IGNORE;
            end
          end
          S_ADDR_ACK: begin
            if (r_rw) begin
              r_state  <= S_RDATA;
              r_shift  <= r_rd_data;
              r_sda_oe <= ~r_rd_data[7];
            end else begin
              r_state  <= S_REG;
              r_sda_oe <= 1'b0;
            end
          end
          S_REG: if (r_bitcnt == 4'd8) begin
            r_ptr    <= r_shift;
            r_bitcnt <= 4'd0;
            r_state  <= S_REG_ACK;
            r_sda_oe <= 1'b1;
          end
          S_REG_ACK: begin
            r_state  <= S_WDATA;
            r_sda_oe <= 1'b0;
          end
          S_WDATA: if (r_bitcnt == 4'd8) begin
            r_bitcnt <= 4'd0;
            r_state  <= S_WDATA_ACK;
            r_sda_oe <= 1'b1;
          end
          S_WDATA_ACK: begin
            r_ptr    <= r_ptr + 8'd1;
            r_state  <= S_WDATA;
            r_sda_oe <= 1'b0;
          end
          // Shift register moves left so bit 6 is always the next bit out
          S_RDATA: begin
            if (r_bitcnt == 4'd8) begin
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA_ACK;
              r_sda_oe <= 1'b0;
            end else begin
              r_sda_oe <= ~r_shift[6];
              r_shift  <= {r_shift[6:0], 1'b0};
            end
          end
          S_RDATA_ACK: begin
            if (!r_mack) begin
              r_state  <= S_RDATA;
              r_shift  <= r_rd_data;
              r_sda_oe <= ~r_rd_data[7];
            end else begin
              r_state  <= S_IGNORE;
              r_sda_oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= 8'h00;
    end else if (w_wr_en && w_ptr_ok) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  // r_rd_data tracks reg[ptr] continuously; ptr settles long before an SCL fall uses it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_data  <= 8'h00;
      r_dbg_data <= 8'h00;
    end else begin
      r_rd_data  <= w_ptr_ok ? r_mem[r_ptr] : 8'h00;
      r_dbg_data <= w_dbg_ok ? r_mem[dbg_addr_i] : 8'h00;
    end
  end

  assign sda_oe_o   = r_sda_oe;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign dbg_data_o = r_dbg_data;
  assign busy_o     = (r_state != S_IDLE) && (r_state != S_IGNORE);

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: directed table, corner-case sequences and
// randomized transactions checked against a transaction-level register model.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
  localparam int H = 10;  // SCL half period in clk cycles

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe_o, wr_valid_o, busy_o;
  logic [7:0] wr_addr_o, wr_data_o, dbg_data_o;
  logic [7:0] dbg_addr_i = 8'h00;

  assign sda_bus = m_sda & ~sda_oe_o;
  always #5 clk_i = ~clk_i;

  i2c_target_regfile dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .scl_i(scl), .sda_i(sda_bus),
    .sda_oe_o(sda_oe_o), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .dbg_addr_i(dbg_addr_i),
    .dbg_data_o(dbg_data_o)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          oe_cnt = 0;
  int          rd_idx = 0;
  logic [7:0]  model_mem [256];
  logic [15:0] exp_wr_q[$];
  logic [15:0] got_wr_q[$];

  always @(negedge clk_i) begin
    if (wr_valid_o) got_wr_q.push_back({wr_addr_o, wr_data_o});
    if (sda_oe_o) oe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; cyc(H/2);
    scl = 1'b1;   cyc(H/2);
    m_sda = 1'b0; cyc(H/2);
    scl = 1'b0;   cyc(H/2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(H/2);
    scl = 1'b1;   cyc(H/2);
    m_sda = 1'b1; cyc(H);
  endtask

  task automatic read_bit(output logic v);
    m_sda = 1'b1; cyc(H/2);
    scl = 1'b1;   cyc(H/2);
    v = sda_bus;  cyc(H/2);
    scl = 1'b0;   cyc(H/2);
  endtask

  // lat: cycles from the last SCL fall until sda_oe_o is seen high (99 = never)
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit with_ack,
                           output bit ack, output int lat);
    logic v;
    ack = 1'b0;
    lat = 99;
    for (int i = 0; i < nbits; i++) begin
      m_sda = b[7-i]; cyc(H/2);
      scl = 1'b1;     cyc(H);
      scl = 1'b0;
      lat = 99;
      for (int k = 1; k <= H/2; k++) begin
        @(negedge clk_i);
        if (sda_oe_o && lat == 99) lat = k;
      end
    end
    if (with_ack) begin
      read_bit(v);
      ack = !v;
    end
  endtask

  task automatic recv_byte(input bit nack, output logic [7:0] b, output logic ack_line);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    m_sda = nack;       cyc(H/2);
    scl = 1'b1;         cyc(H/2);
    ack_line = sda_bus; cyc(H/2);
    scl = 1'b0;         cyc(H/2);
  endtask

  task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
    dbg_addr_i = a;
    @(negedge clk_i);
    d = dbg_data_o;
  endtask

  task automatic run_write(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d[$],
                           output bit a_ack, output int d_acks, output int lat);
    bit ack;
    int l;
    i2c_start();
    send_byte(dev, 8, 1'b1, a_ack, lat);
    send_byte(ra, 8, 1'b1, ack, l);
    d_acks = int'(ack);
    foreach (d[i]) begin
      send_byte(d[i], 8, 1'b1, ack, l);
      d_acks += int'(ack);
    end
    i2c_stop();
  endtask

  task automatic check_pulses(input string tag);
    check({tag, " pulse count"}, 32'(got_wr_q.size() - rd_idx), 32'(exp_wr_q.size()));
    foreach (exp_wr_q[i])
      if (rd_idx + i < got_wr_q.size())
        check({tag, " pulse addr/data"}, 32'(got_wr_q[rd_idx + i]), 32'(exp_wr_q[i]));
    rd_idx = got_wr_q.size();
    exp_wr_q.delete();
  endtask

  // Transaction-level expectation: only 8'h72 is answered; every data byte lands at ptr+i
  task automatic do_write(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d[$],
                          input string tag);
    bit a_ack;
    int d_acks, lat, oe0;
    bit hit;
    hit = (dev == 8'h72);
    oe0 = oe_cnt;
    run_write(dev, ra, d, a_ack, d_acks, lat);
    check({tag, " addr ack"}, 32'(a_ack), 32'(hit));
    check({tag, " data acks"}, 32'(d_acks), hit ? 32'(d.size() + 1) : 32'd0);
    if (hit) begin
      foreach (d[i]) begin
        model_mem[8'(ra + i)] = d[i];
        exp_wr_q.push_back({8'(ra + i), d[i]});
      end
    end else begin
      check({tag, " sda never driven"}, 32'(oe_cnt), 32'(oe0));
    end
    check({tag, " busy after stop"}, 32'(busy_o), 32'd0);
    check_pulses(tag);
  endtask

  task automatic do_read(input logic [7:0] ra, input int n, input string tag);
    bit ack;
    int lat;
    logic [7:0] b;
    logic line;
    i2c_start();
    send_byte(8'h72, 8, 1'b1, ack, lat);
    check({tag, " wr addr ack"}, 32'(ack), 32'd1);
    send_byte(ra, 8, 1'b1, ack, lat);
    check({tag, " reg ack"}, 32'(ack), 32'd1);
    i2c_start();
    send_byte(8'h73, 8, 1'b1, ack, lat);
    check({tag, " rd addr ack"}, 32'(ack), 32'd1);
    check({tag, " busy in read"}, 32'(busy_o), 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b, line);
      check({tag, " read data"}, 32'(b), 32'(model_mem[8'(ra + i)]));
      if (i == n - 1) check({tag, " sda released at nack"}, 32'(line), 32'd1);
    end
    i2c_stop();
    check({tag, " busy after stop"}, 32'(busy_o), 32'd0);
    check_pulses(tag);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ra;
    logic [7:0] data;
    bit         exp_ack;
    int         exp_dacks;
    int         exp_pulses;
    logic [7:0] exp_reg;
  } vec_t;

  initial begin
    vec_t       tbl[6];
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] other;
    bit         a_ack, ack;
    int         d_acks, lat, oe0;

    tbl[0] = '{8'h72, 8'h41, 8'h10, 1'b1, 2, 1, 8'h10};
    tbl[1] = '{8'h74, 8'h50, 8'h55, 1'b0, 0, 0, 8'h00};
    tbl[2] = '{8'h72, 8'h42, 8'h7E, 1'b1, 2, 1, 8'h7E};
    tbl[3] = '{8'h70, 8'h60, 8'h33, 1'b0, 0, 0, 8'h00};
    tbl[4] = '{8'hF2, 8'h61, 8'h44, 1'b0, 0, 0, 8'h00};
    tbl[5] = '{8'h72, 8'hFF, 8'hC3, 1'b1, 2, 1, 8'hC3};
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    cyc(3);
    check("reset sda_oe", 32'(sda_oe_o), 32'd0);
    check("reset wr_valid", 32'(wr_valid_o), 32'd0);
    check("reset wr_addr", 32'(wr_addr_o), 32'd0);
    check("reset wr_data", 32'(wr_data_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset dbg_data", 32'(dbg_data_o), 32'd0);
    rst_n_i = 1'b1;
    cyc(5);

    for (int i = 0; i < 6; i++) begin
      q = '{};
      q.push_back(tbl[i].data);
      oe0 = oe_cnt;
      run_write(tbl[i].dev, tbl[i].ra, q, a_ack, d_acks, lat);
      check($sformatf("tbl%0d addr ack", i), 32'(a_ack), 32'(tbl[i].exp_ack));
      check($sformatf("tbl%0d data acks", i), 32'(d_acks), 32'(tbl[i].exp_dacks));
      if (tbl[i].exp_ack) begin
        check($sformatf("tbl%0d ack latency", i), 32'(lat), 32'd3);
        model_mem[tbl[i].ra] = tbl[i].data;
        exp_wr_q.push_back({tbl[i].ra, tbl[i].data});
      end else begin
        check($sformatf("tbl%0d sda never driven", i), 32'(oe_cnt), 32'(oe0));
      end
      check($sformatf("tbl%0d pulses", i), 32'(got_wr_q.size() - rd_idx), 32'(tbl[i].exp_pulses));
      check_pulses($sformatf("tbl%0d", i));
      dbg_read(tbl[i].ra, d);
      check($sformatf("tbl%0d dbg reg", i), 32'(d), 32'(tbl[i].exp_reg));
      check($sformatf("tbl%0d busy", i), 32'(busy_o), 32'd0);
    end

    // Burst across the top of the address space
    q = '{8'hAA, 8'hBB, 8'hCC};
    do_write(8'h72, 8'hFE, q, "burst");
    dbg_read(8'hFE, d); check("burst reg FE", 32'(d), 32'hAA);
    dbg_read(8'hFF, d); check("burst reg FF", 32'(d), 32'hBB);
    dbg_read(8'h00, d); check("burst reg 00 wrap", 32'(d), 32'hCC);

    do_read(8'h41, 2, "read41");

    // STOP in the middle of a data byte discards it
    i2c_start();
    send_byte(8'h72, 8, 1'b1, ack, lat);
    send_byte(8'h30, 8, 1'b1, ack, lat);
    send_byte(8'hA5, 4, 1'b0, ack, lat);
    i2c_stop();
    check_pulses("partial");
    dbg_read(8'h30, d); check("partial reg unchanged", 32'(d), 32'h00);
    q = '{8'h5A};
    do_write(8'h72, 8'h31, q, "after partial");
    dbg_read(8'h31, d); check("after partial reg", 32'(d), 32'h5A);

    // Reset while the address ACK is being driven
    i2c_start();
    send_byte(8'h72, 8, 1'b0, ack, lat);
    check("pre-reset ack driven", 32'(sda_oe_o), 32'd1);
    check("pre-reset busy", 32'(busy_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("reset releases sda", 32'(sda_oe_o), 32'd0);
    check("reset clears busy", 32'(busy_o), 32'd0);
    cyc(3);
    rst_n_i = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    i2c_stop();
    dbg_read(8'h41, d); check("reset cleared reg41", 32'(d), 32'h00);
    dbg_read(8'hFE, d); check("reset cleared regFE", 32'(d), 32'h00);
    q = '{8'h99, 8'h66};
    do_write(8'h72, 8'h41, q, "post reset");
    do_read(8'h41, 2, "post reset read");

    for (int t = 0; t < 24; t++) begin
      int kind, n;
      logic [7:0] ra;
      kind = $urandom_range(0, 2);
      ra = 8'($urandom_range(0, 255));
      q = '{};
      if (kind < 2) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        other = {7'($urandom_range(0, 127)), 1'b0};
        if (other == 8'h72) other = 8'h74;
        do_write(($urandom_range(0, 3) == 0) ? other : 8'h72, ra, q, $sformatf("rnd%0d wr", t));
      end else begin
        do_read(ra, $urandom_range(1, 3), $sformatf("rnd%0d rd", t));
      end
    end

    for (int a = 0; a < 256; a++) begin
      dbg_read(8'(a), d);
      check($sformatf("sweep reg %0h", a), 32'(d), 32'(model_mem[a]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Synthesizable I2C target (responder) with an 8-bit-addressed register file, the far end of the HDMI controller's I2C configuration initiator. It decodes START/STOP, matches a 7-bit device address, accepts register writes with auto-increment, serves register reads (including repeated-START reads) and exposes every accepted write on a side port. It stands in for the ADV7511 configuration port in loopback builds and benches, so `scl_o`/`sda_io` can be closed on real RTL.

## Interface
- `DEV_ADDR`, 7'h39: 7-bit target address (8-bit write address 0x72).
- `NREGS`, 256: register count; register address width is 8 and addresses ≥ `NREGS` read 0x00 and ignore writes.
- `clk_i`  in  1  system clock; the only clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `scl_i`  in  1  SCL from bus, asynchronous.
- `sda_i`  in  1  SDA from bus, asynchronous.
- `sda_oe_o`  out  1  1 = pull SDA low (open-drain); the top level ties SDA to 0 when high and Z otherwise.
- `wr_valid_o`  out  1  one-cycle pulse per accepted data byte.
- `wr_addr_o`  out  8  register address of that write.
- `wr_data_o`  out  8  data of that write.
- `busy_o`  out  1  high from the addressed START until STOP.
- `dbg_addr_i`  in  8  local read address.
- `dbg_data_o`  out  8  `reg[dbg_addr_i]`, registered, 1-cycle latency.

## Operation
- Two-flop synchronizers on `scl_i`/`sda_i`, plus a registered previous value for edge detection. A bus event reaches the FSM 3 `clk_i` cycles after the pin changes.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are legal in every state.
  - START (including repeated START) goes to ADDR, clears the bit counter and releases SDA.
  - STOP goes to IDLE and releases SDA. A partially received byte is discarded.
- Bits are sampled on the SCL rising edge, MSB first. Outputs change only on the SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: after 8 bits, compare bits[7:1] with `DEV_ADDR`.
  - Match: go to ADDR_ACK and drive ACK.
  - Mismatch: go to IGNORE; never drive SDA until the next START or STOP.
- ADDR_ACK: R/W bit 0 goes to REG; R/W bit 1 goes to RDATA with `reg[ptr]` loaded into the shift register.
- REG: the 8 bits received load `ptr`; ACK, then go to WDATA.
- WDATA: each complete byte writes `reg[ptr]`, pulses `wr_valid_o`, ACKs, then `ptr` increments.
  - `ptr` wraps 0xFF→0x00.
  - Out-of-range `ptr`: the byte is still ACKed and `wr_valid_o` still pulses, but storage is unchanged.
- RDATA: drive the inverse of each shift bit on `sda_oe_o` after each SCL fall, then release SDA for the 9th bit.
  - RDATA_ACK samples the initiator's bit. ACK (0): `ptr`++, reload the shift register, back to RDATA. NACK (1): go to IGNORE.
- ACK timing: `sda_oe_o` rises after the 8th SCL fall and falls after the 9th SCL fall.
- `busy_o` is high in every state except IDLE and IGNORE.
- Reset: all registers, `ptr` and the FSM return to zero/IDLE.

## Timing
- Reset values: `sda_oe_o`=0, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `dbg_data_o`=0.
- `rst_n_i` low mid-transfer releases SDA immediately (asynchronous). After reset the block sits in IDLE until a fresh START.
- `sda_oe_o` changes exactly 3 `clk_i` cycles after the SCL falling edge at the pin.
  - Requirement on the initiator: SCL low ≥ 8 `clk_i` and SDA hold after SCL fall ≥ 4 `clk_i`. The initiator's defaults (DIVIDER=50, DATA_HOLD=5) meet this.
- `wr_valid_o` pulses 3 cycles after the 8th SCL rising edge of the byte, together with `wr_addr_o`/`wr_data_o`. The register content is visible on `dbg_data_o` one cycle later.
- START and SCL rising edge detected in the same cycle: START takes priority.
- A local `dbg_addr_i` read in the same cycle as a write to the same address returns the old value.

## Test plan
- Write 0x72, 0x41, 0x10, STOP → ACK on all three bytes, one `wr_valid_o` pulse (addr 0x41, data 0x10), `dbg_data_o`=0x10 at 0x41, `busy_o` low after STOP.
- Burst 0x72, 0xFE, 0xAA, 0xBB, 0xCC → `reg[FE]`=AA, `reg[FF]`=BB, `reg[00]`=CC (wrap), three pulses.
- Read: 0x72, 0x41, Sr, 0x73, read two bytes (ACK then NACK) → SDA returns `reg[41]` then `reg[42]`; SDA released after NACK; no `wr_valid_o`.
- Address 0x74 with data 0x55 → SDA never driven (NACK seen), no pulses, registers unchanged.
- STOP after 4 bits of a data byte → no write; the next 0x72 transaction is accepted normally.
- `rst_n_i` low while SDA is driven for ACK → `sda_oe_o`=0 in the same cycle, registers cleared, next transaction correct.
